// File: rtl/partial_sum_accumulator.sv
// Framed multi-operand accumulator: folds unsigned TERM_W-bit terms into a
// wrapping ACC_W-bit sum and hands the result, term count and flags downstream.
module partial_sum_accumulator #(
  parameter int TERM_W    = 43,
  parameter int ACC_W     = 45,
  parameter int CNT_W     = 8,
  parameter int MAX_TERMS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TERM_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_trunc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t           state;
  state_t           next_state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             trunc;
  logic             accept;
  logic             hit_max;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum_ext;

  // Zero-extended add: bit ACC_W of the result is the carry out of the accumulator.
  function automatic logic [ACC_W:0] add_term(input logic [ACC_W-1:0] a,
                                              input logic [TERM_W-1:0] t);
    add_term = {1'b0, a} + {{(ACC_W + 1 - TERM_W){1'b0}}, t};
  endfunction

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
  assign hit_max = (cnt_inc == MAX_CNT);
  assign sum_ext = add_term(acc, in_data);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a frame closes on in_last or when the term budget is used up.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          if (in_last || hit_max) begin
            next_state = DONE;
          end else begin
            next_state = ACC;
          end
        end else begin
          next_state = state;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACC: begin
        in_ready  = ~rst;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accumulator datapath; cleared on the output handshake so IDLE always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= {ACC_W{1'b0}};
      cnt   <= {CNT_W{1'b0}};
      ovf   <= 1'b0;
      trunc <= 1'b0;
    end else if (state == DONE) begin
      if (out_ready) begin
        acc   <= {ACC_W{1'b0}};
        cnt   <= {CNT_W{1'b0}};
        ovf   <= 1'b0;
        trunc <= 1'b0;
      end else begin
        acc   <= acc;
        cnt   <= cnt;
        ovf   <= ovf;
        trunc <= trunc;
      end
    end else if (accept) begin
      acc   <= sum_ext[ACC_W-1:0];
      cnt   <= cnt_inc;
      ovf   <= ovf | sum_ext[ACC_W];
      trunc <= hit_max & ~in_last;
    end else begin
      acc   <= acc;
      cnt   <= cnt;
      ovf   <= ovf;
      trunc <= trunc;
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;
  assign out_trunc = trunc;

endmodule
